// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, address-split and cache-frame types
// Default-geometry views (16 one-word frames) of the instruction cache address
// split and frame layout; parameterised instances slice the address directly.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  localparam int ICACHE_NSETS = 16;
  localparam int ICACHE_IDXW = $clog2(ICACHE_NSETS);
  localparam int ICACHE_TAGW = 30 - ICACHE_IDXW;
  typedef struct packed {
    logic [ICACHE_TAGW-1:0] tag;
    logic [ICACHE_IDXW-1:0] idx;
    logic [1:0]             bytoff;
  } icachef_t;
  typedef struct packed {
    logic                   valid;
    logic [ICACHE_TAGW-1:0] tag;
    word_t                  data;
  } icache_frame_t;
endpackage

// File: rtl/dp_types_pkg.sv
// dp_types_pkg: datapath/cache control enumerations
package dp_types_pkg;
  typedef enum logic {IDLE, FETCH} icache_state_t;
endpackage

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache, one word per frame
// Ports:
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   imemREN, imemaddr    fetch request from the datapath
//   ihit, imemload       same-cycle hit indication and instruction word
//   iREN, iaddr          single-word read request to the memory controller
//   iwait, iload         memory busy flag and read data (valid when iwait=0)
//   hit_count            saturating count of cycles with ihit=1
//   miss_count           saturating count of fills started
module icache
  import cpu_types_pkg::*;
  import dp_types_pkg::*;
#(
  parameter int NSETS = 16
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload,
  output word_t hit_count,
  output word_t miss_count
);
  localparam int IDXW = $clog2(NSETS);
  localparam int TAGW = 30 - IDXW;
  typedef struct packed {
    logic            valid;
    logic [TAGW-1:0] tag;
    word_t           data;
  } frame_t;
  frame_t          frames [NSETS];
  icache_state_t   state, next_state;
  word_t           miss_addr;
  logic [IDXW-1:0] idx, fidx;
  logic [TAGW-1:0] tag;
  logic            miss, fill;
  assign idx  = imemaddr[IDXW+1:2];
  assign tag  = imemaddr[31:IDXW+2];
  assign fidx = miss_addr[IDXW+1:2];
  assign ihit = imemREN && state == IDLE && frames[idx].valid && frames[idx].tag == tag;
  assign imemload = ihit ? frames[idx].data : '0;
  assign miss = imemREN && state == IDLE && !ihit;
  // a started fill always completes, even if the fetch stage redirects meanwhile
  assign fill = state == FETCH && !iwait;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = miss ? FETCH : fill ? IDLE : state;
    iREN = state == FETCH;
    iaddr = iREN ? miss_addr : '0;
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) miss_addr <= '0;
    else if (miss) miss_addr <= {imemaddr[31:2], 2'b00};
  // only valid bits are reset; tag/data are qualified by valid
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      for (int i = 0; i < NSETS; i++) frames[i].valid <= 1'b0;
    end else if (fill) begin
      frames[fidx] <= '{valid: 1'b1, tag: miss_addr[31:IDXW+2], data: iload};
    end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      hit_count  <= (ihit && hit_count != '1) ? hit_count + 1 : hit_count;
      miss_count <= (miss && miss_count != '1) ? miss_count + 1 : miss_count;
    end
endmodule

// File: tb/tb_icache.sv
// tb_icache: scoreboard bench for icache with a wait-state memory model
module tb_icache;
  import cpu_types_pkg::*;
  logic  CLK = 0, nRST = 0, imemREN = 0;
  logic  ihit, iREN, iwait;
  word_t imemaddr = '0, imemload, iaddr, iload, hit_count, miss_count;
  int    checks = 0, errors = 0, mem_wait = 3, wcnt;
  word_t exp_q [$];

  icache #(.NSETS(16)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  function automatic word_t memword(input word_t a);
    return a == 32'h0 ? 32'h2401_0005 : a == 32'h40 ? 32'hAAAA_AAAA : a ^ 32'h5A5A_0000;
  endfunction

  // memory holds iwait high for mem_wait cycles of each request
  always @(posedge CLK or negedge nRST)
    if (!nRST) wcnt <= 0;
    else wcnt <= (iREN && wcnt != mem_wait) ? wcnt + 1 : 0;
  assign iwait = !(iREN && wcnt == mem_wait);
  assign iload = iwait ? 32'hDEAD_BEEF : memword(iaddr);

  task automatic check(input string tag, input word_t got, input word_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // present a read at a negedge and wait (bounded) for the hit
  task automatic fetch(input word_t a, input int lat, input int nren);
    int c = 0, r = 0;
    imemREN = 1;
    imemaddr = a;
    exp_q.push_back(memword(a));
    #1;
    while (!ihit && c < 40) begin
      if (iREN) begin
        r++;
        check("iaddr", iaddr, a);
      end
      @(negedge CLK);
      c++;
    end
    check("latency", word_t'(c), word_t'(lat));
    check("iren_cycles", word_t'(r), word_t'(nren));
    check("imemload", imemload, exp_q.pop_front());
    @(negedge CLK);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    check("rst_ihit", word_t'(ihit), 0);
    check("rst_imemload", imemload, 0);
    check("rst_iren", word_t'(iREN), 0);
    check("rst_iaddr", iaddr, 0);
    check("rst_hits", hit_count, 0);
    check("rst_misses", miss_count, 0);
    nRST = 1;
    @(negedge CLK);
    mem_wait = 3;
    fetch(32'h0, 5, 4);
    check("t1_misses", miss_count, 1);
    check("t1_hits", hit_count, 1);
    repeat (4) fetch(32'h0, 0, 0);
    check("t2_hits", hit_count, 5);
    check("t2_misses", miss_count, 1);
    imemREN = 0;
    imemaddr = 32'h40;
    #1;
    check("idle_ihit", word_t'(ihit), 0);
    check("idle_load", imemload, 0);
    repeat (3) @(negedge CLK);
    check("idle_iren", word_t'(iREN), 0);
    check("idle_hits", hit_count, 5);
    check("idle_misses", miss_count, 1);
    mem_wait = 0;
    fetch(32'h40, 2, 1);
    check("conf_misses", miss_count, 2);
    fetch(32'h0, 2, 1);
    check("refetch_misses", miss_count, 3);
    mem_wait = 2;
    imemREN = 1;
    imemaddr = 32'h10;
    @(negedge CLK);
    check("redir_iren", word_t'(iREN), 1);
    check("redir_iaddr", iaddr, 32'h10);
    imemREN = 0;
    imemaddr = 32'h20;
    for (int i = 0; i < 20 && iREN; i++) @(negedge CLK);
    check("redir_done", word_t'(iREN), 0);
    check("redir_misses", miss_count, 4);
    fetch(32'h10, 0, 0);
    fetch(32'h20, 4, 3);
    check("redir2_misses", miss_count, 5);
    check("redir_hits", hit_count, 9);
    mem_wait = 3;
    imemREN = 1;
    imemaddr = 32'h80;
    @(negedge CLK);
    check("prerst_iren", word_t'(iREN), 1);
    nRST = 0;
    #1;
    check("arst_iren", word_t'(iREN), 0);
    check("arst_iaddr", iaddr, 0);
    check("arst_hits", hit_count, 0);
    check("arst_misses", miss_count, 0);
    @(negedge CLK);
    nRST = 1;
    imemREN = 0;
    @(negedge CLK);
    fetch(32'h0, 5, 4);
    check("post_rst_misses", miss_count, 1);
    check("post_rst_hits", hit_count, 1);
    imemREN = 1;
    imemaddr = 32'h0;
    #1;
    check("sat_ihit", word_t'(ihit), 1);
    force dut.hit_count = 32'hFFFF_FFFE;
    #1;
    release dut.hit_count;
    @(negedge CLK);
    check("sat_hits1", hit_count, 32'hFFFF_FFFF);
    @(negedge CLK);
    check("sat_hits2", hit_count, 32'hFFFF_FFFF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
